m_dm_responder: RTL and testbench

//  Data-memory responder at the memory end of the CPU store/load path.

---
 rtl/m_dm_responder_if.sv | 29 ++
 rtl/m_dm_responder.sv | 189 ++++++++++++++++++
 tb/tb_m_dm_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/m_dm_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : m_dm_responder_if
// Description : Request/response bundle between the CPU store/load path and
//               the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface m_dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [3:0]  req_byteen;
    logic [31:0] req_wdata;
    logic [2:0]  req_loadtype;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_byteen, req_wdata, req_loadtype,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_byteen, req_wdata, req_loadtype,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/m_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : m_dm_responder
// Description : Single-outstanding data-memory responder with byte-lane
//               writes, extended loads and request legality checking.
// Revision    : 1.0 - initial release
// ============================================================================
module m_dm_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic            clk,
    input  logic            reset,
    m_dm_responder_if.slave bus
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [2:0]  CNT_INIT = 3'(READ_LAT > 1 ? READ_LAT - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] rdata, rdata_nxt;
    logic        err, err_nxt;
    logic [31:0] word_q, word_nxt;
    logic [1:0]  lane_q, lane_nxt;
    logic [2:0]  lt_q, lt_nxt;
    logic        ready, valid;

    logic [31:0] mem [DEPTH];

    logic [29:0]           word_off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  range_err, mask_err, load_err, is_write, req_err;
    logic                  accept;
    logic [31:0]           mem_word;

    assign word_off  = bus.req_addr[31:2] - BASE_ADDR[31:2];
    assign idx       = word_off[ADDR_WIDTH-1:0];
    assign range_err = (bus.req_addr < BASE_ADDR) ||
                       ({1'b0, word_off} >= (31'd1 << ADDR_WIDTH));
    assign is_write  = (bus.req_byteen != 4'b0000);
    assign mem_word  = mem[idx];
    assign accept    = bus.req_valid && (state == IDLE);

    // Mask must match the lane(s) the address points at.
    always_comb begin
        mask_err = 1'b1;
        case (bus.req_byteen)
            4'b1111: mask_err = (bus.req_addr[1:0] != 2'd0);
            4'b0001: mask_err = (bus.req_addr[1:0] != 2'd0);
            4'b0010: mask_err = (bus.req_addr[1:0] != 2'd1);
            4'b0100: mask_err = (bus.req_addr[1:0] != 2'd2);
            4'b1000: mask_err = (bus.req_addr[1:0] != 2'd3);
            4'b0011: mask_err = bus.req_addr[1];
            4'b1100: mask_err = !bus.req_addr[1];
            default: mask_err = 1'b1;
        endcase
    end

    always_comb begin
        load_err = 1'b1;
        case (bus.req_loadtype)
            3'd0:       load_err = (bus.req_addr[1:0] != 2'd0);
            3'd1, 3'd2: load_err = 1'b0;
            3'd3, 3'd4: load_err = bus.req_addr[0];
            default:    load_err = 1'b1;
        endcase
    end

    assign req_err = range_err || (is_write ? mask_err : load_err);

    function automatic logic [31:0] extend(input logic [31:0] w,
                                           input logic [1:0]  a,
                                           input logic [2:0]  lt);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (lt)
            3'd1:    extend = {{24{b[7]}}, b};
            3'd2:    extend = {24'd0, b};
            3'd3:    extend = {{16{h[15]}}, h};
            3'd4:    extend = {16'd0, h};
            default: extend = w;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata;
        err_nxt   = err;
        word_nxt  = word_q;
        lane_nxt  = lane_q;
        lt_nxt    = lt_q;
        ready     = 1'b0;
        valid     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    word_nxt = mem_word;
                    lane_nxt = bus.req_addr[1:0];
                    lt_nxt   = bus.req_loadtype;
                    if (req_err || is_write) begin
                        state_nxt = RESP;
                        err_nxt   = req_err;
                        rdata_nxt = 32'd0;
                    end else if (READ_LAT == 1) begin
                        // Single-cycle reads respond with write timing.
                        state_nxt = RESP;
                        err_nxt   = 1'b0;
                        rdata_nxt = extend(mem_word, bus.req_addr[1:0],
                                           bus.req_loadtype);
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                    cnt_nxt   = 3'd0;
                    err_nxt   = 1'b0;
                    rdata_nxt = extend(word_q, lane_q, lt_q);
                end
            end
            RESP: begin
                valid     = 1'b1;
                state_nxt = IDLE;
                rdata_nxt = 32'd0;
                err_nxt   = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            rdata  <= 32'd0;
            err    <= 1'b0;
            word_q <= 32'd0;
            lane_q <= 2'd0;
            lt_q   <= 3'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rdata  <= rdata_nxt;
            err    <= err_nxt;
            word_q <= word_nxt;
            lane_q <= lane_nxt;
            lt_q   <= lt_nxt;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (reset && accept && is_write && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_byteen[i]) begin
                    mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = valid;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;

endmodule
`default_nettype wire

// File: tb/tb_m_dm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_dm_responder
// Description : Directed bench for m_dm_responder at READ_LAT 1, 3 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_dm_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    m_dm_responder_if b0 ();
    m_dm_responder_if b1 ();
    m_dm_responder_if b2 ();

    m_dm_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .READ_LAT(1))
        u_l1 (.clk(clk), .reset(rst0), .bus(b0.slave));
    m_dm_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .READ_LAT(3))
        u_l3 (.clk(clk), .reset(rst1), .bus(b1.slave));
    m_dm_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .READ_LAT(4))
        u_l4 (.clk(clk), .reset(rst2), .bus(b2.slave));

    // One set of request drivers, steered to the instance chosen by sel.
    logic [1:0]  sel;
    logic        vld;
    logic [31:0] addr, wd;
    logic [3:0]  be;
    logic [2:0]  lt;

    assign b0.req_valid = vld && (sel == 2'd0);
    assign b1.req_valid = vld && (sel == 2'd1);
    assign b2.req_valid = vld && (sel == 2'd2);
    assign b0.req_addr = addr;  assign b1.req_addr = addr;  assign b2.req_addr = addr;
    assign b0.req_byteen = be;  assign b1.req_byteen = be;  assign b2.req_byteen = be;
    assign b0.req_wdata = wd;   assign b1.req_wdata = wd;   assign b2.req_wdata = wd;
    assign b0.req_loadtype = lt; assign b1.req_loadtype = lt; assign b2.req_loadtype = lt;

    logic        rdy, rv, rerr;
    logic [31:0] rdat;
    always_comb begin
        case (sel)
            2'd1:    begin rdy = b1.req_ready; rv = b1.rsp_valid; rdat = b1.rsp_rdata; rerr = b1.rsp_err; end
            2'd2:    begin rdy = b2.req_ready; rv = b2.rsp_valid; rdat = b2.rsp_rdata; rerr = b2.rsp_err; end
            default: begin rdy = b0.req_ready; rv = b0.rsp_valid; rdat = b0.rsp_rdata; rerr = b0.rsp_err; end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Called at #1 after an edge; returns response fields, latency counted
    // with the accept edge as edge 1, whether ready was seen while busy, and
    // whether rsp_valid stayed high past one cycle.
    task automatic do_req(input logic [31:0] a, input logic [3:0] b, input logic [31:0] w,
                          input logic [2:0] t, output logic [31:0] d, output logic e,
                          output int lat, output logic busy_rdy, output logic wide);
        int n;
        d = 32'hx; e = 1'bx; lat = 0; busy_rdy = 1'b0; wide = 1'b0;
        addr = a; be = b; wd = w; lt = t; vld = 1'b1;
        n = 0;
        while (!rdy && n < 20) begin @(posedge clk); #1; n++; end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL accept_timeout got=ready_low expected=ready_high");
            vld = 1'b0;
            return;
        end
        @(posedge clk); #1;
        vld = 1'b0; addr = 32'hFFFF_FFFF; be = 4'b0101; wd = 32'hFFFF_FFFF; lt = 3'd7;
        lat = 1;
        while (!rv && lat < 20) begin
            if (rdy) busy_rdy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        d = rdat; e = rerr;
        if (rdy) busy_rdy = 1'b1;
        @(posedge clk); #1;
        wide = rv;
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] w;
        logic [2:0]  t;
        logic [31:0] xd;
        logic        xe;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] d;
    logic        e, busy, wide;
    int          lat;

    initial begin
        vecs.push_back('{"sw_10",     32'h10,   4'b1111, 32'hDEADBEEF, 3'd0, 32'h0,        1'b0});
        vecs.push_back('{"lw_10",     32'h10,   4'b0000, 32'h0,        3'd0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"sb_13",     32'h13,   4'b1000, 32'h7F000000, 3'd0, 32'h0,        1'b0});
        vecs.push_back('{"lw_10_b",   32'h10,   4'b0000, 32'h0,        3'd0, 32'h7FADBEEF, 1'b0});
        vecs.push_back('{"lb_11",     32'h11,   4'b0000, 32'h0,        3'd1, 32'hFFFFFFBE, 1'b0});
        vecs.push_back('{"lbu_11",    32'h11,   4'b0000, 32'h0,        3'd2, 32'h000000BE, 1'b0});
        vecs.push_back('{"e_lh_11",   32'h11,   4'b0000, 32'h0,        3'd3, 32'h0,        1'b1});
        vecs.push_back('{"e_sw_12",   32'h12,   4'b1111, 32'h11111111, 3'd0, 32'h0,        1'b1});
        vecs.push_back('{"e_sb_10",   32'h10,   4'b0010, 32'h0000AA00, 3'd0, 32'h0,        1'b1});
        vecs.push_back('{"e_m0101",   32'h10,   4'b0101, 32'h22222222, 3'd0, 32'h0,        1'b1});
        vecs.push_back('{"e_range",   32'h4000, 4'b1111, 32'h33333333, 3'd0, 32'h0,        1'b1});
        vecs.push_back('{"e_lt5",     32'h10,   4'b0000, 32'h0,        3'd5, 32'h0,        1'b1});
        vecs.push_back('{"lw_unchg",  32'h10,   4'b0000, 32'h0,        3'd0, 32'h7FADBEEF, 1'b0});
        vecs.push_back('{"sw_last",   32'h3FFC, 4'b1111, 32'h12345678, 3'd0, 32'h0,        1'b0});
        vecs.push_back('{"lw_last",   32'h3FFC, 4'b0000, 32'h0,        3'd0, 32'h12345678, 1'b0});
        vecs.push_back('{"e_lw_rng",  32'h4000, 4'b0000, 32'h0,        3'd0, 32'h0,        1'b1});
        vecs.push_back('{"sw_10_c",   32'h10,   4'b1111, 32'h80017FFF, 3'd0, 32'h0,        1'b0});
        vecs.push_back('{"lh_12",     32'h12,   4'b0000, 32'h0,        3'd3, 32'hFFFF8001, 1'b0});
        vecs.push_back('{"lhu_12",    32'h12,   4'b0000, 32'h0,        3'd4, 32'h00008001, 1'b0});
        vecs.push_back('{"lh_10",     32'h10,   4'b0000, 32'h0,        3'd3, 32'h00007FFF, 1'b0});
        vecs.push_back('{"lb_13",     32'h13,   4'b0000, 32'h0,        3'd1, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{"lbu_10",    32'h10,   4'b0000, 32'h0,        3'd2, 32'h000000FF, 1'b0});
        vecs.push_back('{"sh_12",     32'h12,   4'b1100, 32'hCAFE0000, 3'd0, 32'h0,        1'b0});
        vecs.push_back('{"e_sh_12",   32'h12,   4'b0011, 32'h0000BEEF, 3'd0, 32'h0,        1'b1});
        vecs.push_back('{"lw_sh",     32'h10,   4'b0000, 32'h0,        3'd0, 32'hCAFE7FFF, 1'b0});

        sel = 2'd0; vld = 1'b0; addr = 32'h0; be = 4'h0; wd = 32'h0; lt = 3'd0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", {31'd0, rdy}, 32'd1);
        chk("rst_valid", {31'd0, rv}, 32'd0);
        chk("rst_rdata", rdat, 32'd0);
        chk("rst_err", {31'd0, rerr}, 32'd0);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].t, d, e, lat, busy, wide);
            chk({vecs[i].nm, "_data"}, d, vecs[i].xd);
            chk({vecs[i].nm, "_err"}, {31'd0, e}, {31'd0, vecs[i].xe});
            chk({vecs[i].nm, "_lat"}, lat, 32'd1);
            chk({vecs[i].nm, "_wide"}, {31'd0, wide}, 32'd0);
        end

        // Back-to-back write/read/write with valid held high.
        begin
            logic [31:0] qa[3], qw[3], qx[3];
            logic [3:0]  qb[3];
            int k, r;
            logic acc, prev_rv;
            qa = '{32'h30, 32'h30, 32'h34};
            qb = '{4'b1111, 4'b0000, 4'b1111};
            qw = '{32'hA5A5A5A5, 32'h0, 32'h01020304};
            qx = '{32'h0, 32'hA5A5A5A5, 32'h0};
            k = 0; r = 0; prev_rv = 1'b0;
            for (int c = 0; c < 14; c++) begin
                if (k < 3) begin
                    addr = qa[k]; be = qb[k]; wd = qw[k]; lt = 3'd0; vld = 1'b1;
                end else begin
                    vld = 1'b0;
                end
                if (rv) begin
                    if (r < 3) chk($sformatf("b2b_data%0d", r), rdat, qx[r]);
                    chk($sformatf("b2b_rdy_excl%0d", r), {31'd0, rdy}, 32'd0);
                    chk($sformatf("b2b_pulse%0d", r), {31'd0, prev_rv}, 32'd0);
                    r++;
                end
                prev_rv = rv;
                acc = vld && rdy;
                @(posedge clk); #1;
                if (acc) k++;
            end
            vld = 1'b0;
            chk("b2b_accepts", k, 32'd3);
            chk("b2b_responses", r, 32'd3);
            do_req(32'h34, 4'b0000, 32'h0, 3'd0, d, e, lat, busy, wide);
            chk("b2b_lw34", d, 32'h01020304);
        end

        // READ_LAT=3 instance.
        sel = 2'd1; @(posedge clk); #1;
        do_req(32'h20, 4'b1111, 32'h80017FFF, 3'd0, d, e, lat, busy, wide);
        chk("l3_sw_lat", lat, 32'd1);
        do_req(32'h22, 4'b0000, 32'h0, 3'd3, d, e, lat, busy, wide);
        chk("l3_lh_data", d, 32'hFFFF8001);
        chk("l3_lh_lat", lat, 32'd3);
        chk("l3_lh_busy", {31'd0, busy}, 32'd0);
        chk("l3_lh_wide", {31'd0, wide}, 32'd0);
        do_req(32'h22, 4'b0000, 32'h0, 3'd4, d, e, lat, busy, wide);
        chk("l3_lhu_data", d, 32'h00008001);
        chk("l3_lhu_lat", lat, 32'd3);
        do_req(32'h21, 4'b0000, 32'h0, 3'd0, d, e, lat, busy, wide);
        chk("l3_elw_err", {31'd0, e}, 32'd1);
        chk("l3_elw_lat", lat, 32'd1);

        // READ_LAT=4 instance: reset while waiting abandons the read.
        sel = 2'd2; @(posedge clk); #1;
        do_req(32'h40, 4'b1111, 32'h5555AAAA, 3'd0, d, e, lat, busy, wide);
        chk("l4_sw_err", {31'd0, e}, 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            addr = 32'h40; be = 4'b0000; lt = 3'd0; vld = 1'b1;
            @(posedge clk); #1;
            vld = 1'b0;
            chk("l4_wait_busy", {31'd0, rdy}, 32'd0);
            @(posedge clk); #1;
            rst2 = 1'b0;
            seen = rv;
            @(posedge clk); #1;
            rst2 = 1'b1;
            seen = seen | rv;
            chk("l4_rdy_after_rst", {31'd0, rdy}, 32'd1);
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                seen = seen | rv;
            end
            chk("l4_no_rsp", {31'd0, seen}, 32'd0);
        end
        do_req(32'h40, 4'b0000, 32'h0, 3'd0, d, e, lat, busy, wide);
        chk("l4_lw_data", d, 32'h5555AAAA);
        chk("l4_lw_lat", lat, 32'd4);
        chk("l4_lw_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
